mc_controller: RTL

- Multicycle main control FSM for the 32-bit RISC core. It is the producer side of the aluop/funct interface that the ALU decoder consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath enables, mux selects and a 2-bit aluop.
- Stalls on a simple req/ready memory handshake.

---
 rtl/mc_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Optional feature macro ILLEGAL_TRAP_EN: illegal opcodes halt the core and raise 'illegal' instead of acting as NOPs.
module mc_controller #(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct_in,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [FUNCT_W-1:0]  funct,
  output logic [1:0]          aluop,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic                pcwrite,
  output logic                irwrite,
  output logic                iord,
  output logic                mem_req,
  output logic                memwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                halted,
  output logic                illegal
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, IMMEX, IMMWB, BEQEX, JEX, HALT
  } state_t;

  state_t state, next_state;
  logic [OPCODE_W-1:0] op_q;
  logic op_illegal;
  logic illegal_q;

  assign op_illegal = !(opcode inside {OP_R, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // Opcode captured while decoding so later IR updates cannot redirect the instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               op_q <= '0;
    else if (state == DECODE) op_q <= opcode;
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             illegal_q <= 1'b0;
    else if (state == DECODE && op_illegal) illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

  // Every output is gated by reset so an abort drops write strobes without waiting for a clock.
  always_comb begin
    next_state = state;
    funct    = '0;
    aluop    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    mem_req  = 1'b0;
    memwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    if (reset) begin
      funct   = funct_in;
      illegal = illegal_q;
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          aluop   = 2'b11;
          irwrite = mem_ready;
          pcwrite = mem_ready;
          if (mem_ready) next_state = DECODE;
        end
        DECODE: begin
          alusrcb = 2'b10;
          aluop   = 2'b11;
          if (op_illegal) begin
`ifdef ILLEGAL_TRAP_EN
            next_state = HALT;
`else
            next_state = FETCH;
`endif
          end else begin
            case (opcode)
              OP_LW, OP_SW:     next_state = MEMADR;
              OP_R:             next_state = RTYPEEX;
              OP_ADDI, OP_SLTI: next_state = IMMEX;
              OP_BEQ:           next_state = BEQEX;
              OP_J:             next_state = JEX;
              default:          next_state = HALT;
            endcase
          end
        end
        MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          aluop      = 2'b11;
          next_state = (op_q == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) next_state = MEMWB;
        end
        MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          next_state = FETCH;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          memwrite = 1'b1;
          iord     = 1'b1;
          if (mem_ready) next_state = FETCH;
        end
        RTYPEEX: begin
          alusrca    = 1'b1;
          next_state = RTYPEWB;
        end
        RTYPEWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          next_state = FETCH;
        end
        IMMEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          aluop      = (op_q == OP_SLTI) ? 2'b01 : 2'b11;
          next_state = IMMWB;
        end
        IMMWB: begin
          regwrite   = 1'b1;
          next_state = FETCH;
        end
        BEQEX: begin
          alusrca    = 1'b1;
          aluop      = 2'b10;
          pcsrc      = 2'b01;
          pcwrite    = zero;
          next_state = FETCH;
        end
        JEX: begin
          pcsrc      = 2'b10;
          pcwrite    = 1'b1;
          next_state = FETCH;
        end
        HALT: begin
          halted = 1'b1;
        end
        default: next_state = FETCH;
      endcase
    end
  end

endmodule
